// File: rtl/rom_to_ram_copier.sv
// Copies an 8-word combinational ROM into an internal RAM, then re-reads the ROM
// to verify the copy, latching the address of the first mismatching word.
module rom_to_ram_copier #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [DATA_W-1:0] ram_r [DEPTH];
    logic              last_s;
    logic              ram_we_s;
    logic              mismatch_s;
    logic              err_clr_s;
    logic [ADDR_W-1:0] addr_next_s;

    // The terminal count is handled by the state transition, so the counter never wraps mid-pass.
    assign last_s = (rom_addr == LAST_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = COPY;
                else       next_state_s = IDLE;
            end
            COPY: begin
                if (last_s) next_state_s = VERIFY;
                else        next_state_s = COPY;
            end
            VERIFY: begin
                if (last_s) next_state_s = DONE;
                else        next_state_s = VERIFY;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        ram_we_s    = 1'b0;
        mismatch_s  = 1'b0;
        err_clr_s   = 1'b0;
        addr_next_s = ZERO_ADDR;
        case (state_r)
            IDLE: begin
                err_clr_s = start;
            end
            COPY: begin
                ram_we_s    = 1'b1;
                addr_next_s = last_s ? ZERO_ADDR : rom_addr + ONE_ADDR;
            end
            VERIFY: begin
                mismatch_s  = (ram_r[rom_addr] != rom_data);
                addr_next_s = last_s ? ZERO_ADDR : rom_addr + ONE_ADDR;
            end
            DONE: begin
                addr_next_s = ZERO_ADDR;
            end
            default: begin
                addr_next_s = ZERO_ADDR;
            end
        endcase
    end

    // Registered outputs; err/err_addr keep the first mismatch until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= ZERO_ADDR;
            rd_data  <= {DATA_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= ZERO_ADDR;
        end else begin
            rom_addr <= addr_next_s;
            rd_data  <= ram_r[rd_addr];
            busy     <= (next_state_s == COPY) || (next_state_s == VERIFY);
            done     <= (next_state_s == DONE);
            if (err_clr_s) begin
                err      <= 1'b0;
                err_addr <= ZERO_ADDR;
            end else if (mismatch_s && !err) begin
                err      <= 1'b1;
                err_addr <= rom_addr;
            end
        end
    end

    // RAM write port; contents deliberately survive rst
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[rom_addr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_to_ram_copier.sv
// Randomised scoreboard bench for rom_to_ram_copier: a bench-side ROM and RAM image
// predict read-back data and the verify outcome of each copy+verify sequence.
module tb_rom_to_ram_copier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] rom_base [8];
    logic [3:0] corrupt  [8];
    logic [3:0] ram_model[8];
    bit         ram_known[8];
    logic [7:0] mask;
    bit         verify_win;
    bit         rd_req = 1'b0;
    bit         rd_chk = 1'b0;
    bit         exp_err;
    logic [2:0] exp_err_addr;

    typedef struct {logic [3:0] val; bit care;} rd_exp_t;
    typedef struct {bit e; logic [2:0] a; int c;} done_exp_t;
    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];

    always #5 clk = ~clk;

    // Bench ROM; selected words are corrupted only while the verify pass runs
    assign rom_data = (verify_win && mask[rom_addr]) ? corrupt[rom_addr] : rom_base[rom_addr];

    rom_to_ram_copier #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err), .err_addr(err_addr)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_chk <= rd_req;
    end

    // Monitor: pops expectations whenever the DUT presents read data or a done pulse
    always @(negedge clk) begin
        rd_exp_t   x;
        done_exp_t d;
        if (rd_chk) begin
            if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
            else begin
                x = rd_q.pop_front();
                if (x.care) chk("rd_data", int'(rd_data), int'(x.val));
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.c);
                chk("err_at_done", int'(err), int'(d.e));
                chk("err_addr_at_done", int'(err_addr), int'(d.a));
            end
        end
    end

    task automatic set_read(input logic [2:0] a);
        rd_exp_t x;
        rd_addr = a;
        rd_req  = 1'b1;
        x.val   = ram_model[a];
        x.care  = ram_known[a];
        rd_q.push_back(x);
    endtask

    task automatic idle_cycle(input logic [2:0] a);
        start      = 1'b0;
        verify_win = 1'b0;
        set_read(a);
        @(posedge clk);
        @(negedge clk);
        chk("idle_rom_addr", int'(rom_addr), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_err_hold", int'(err), int'(exp_err));
        chk("idle_err_addr_hold", int'(err_addr), int'(exp_err_addr));
    endtask

    // One full copy+verify sequence, entered just after a falling edge with the DUT in IDLE.
    // spat[k] is the start level presented to edge k (k>=1); edge 0 always samples start=1.
    task automatic run_seq(input logic [17:0] spat);
        int         t0;
        int         ea_i;
        bit         e;
        logic [2:0] ea;
        e  = 1'b0;
        ea = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && corrupt[i] != rom_base[i]) begin
                e  = 1'b1;
                ea = 3'(i);
            end
        end
        for (int k = 0; k <= 17; k++) begin
            start      = (k == 0) ? 1'b1 : spat[k];
            verify_win = (k >= 9 && k <= 16);
            set_read(3'($urandom_range(0, 7)));
            @(posedge clk);
            if (k >= 1 && k <= 8) begin
                ram_model[k-1] = rom_base[k-1];
                ram_known[k-1] = 1'b1;
            end
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                done_q.push_back('{e, ea, t0 + 16});
                chk("err_cleared_by_start", int'(err), 0);
                chk("err_addr_cleared_by_start", int'(err_addr), 0);
            end
            ea_i = (k >= 1 && k <= 7) ? k : ((k >= 9 && k <= 15) ? k - 8 : 0);
            chk("seq_busy", int'(busy), int'(k <= 15));
            chk("seq_done", int'(done), int'(k == 16));
            chk("seq_rom_addr", int'(rom_addr), ea_i);
        end
        verify_win   = 1'b0;
        exp_err      = e;
        exp_err_addr = ea;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        rd_addr    = 3'd0;
        verify_win = 1'b0;
        mask       = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rom_base[i]  = 4'(i + 5);
            corrupt[i]   = 4'd0;
            ram_known[i] = 1'b0;
        end
        exp_err      = 1'b0;
        exp_err_addr = 3'd0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_addr", int'(err_addr), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        repeat (10) idle_cycle(3'($urandom_range(0, 7)));

        // Nominal copy of 5..C, then read back every word
        run_seq(18'd0);
        for (int i = 0; i < 8; i++) idle_cycle(3'(i));

        // Single verify mismatch at address 3, then a clean pass clears err
        mask       = 8'b0000_1000;
        corrupt[3] = 4'hF;
        run_seq(18'd0);
        repeat (3) idle_cycle(3'($urandom_range(0, 7)));
        mask = 8'd0;
        run_seq(18'd0);
        repeat (3) idle_cycle(3'($urandom_range(0, 7)));

        // Two mismatches: the first one wins
        mask       = 8'b0100_0100;
        corrupt[2] = ~rom_base[2];
        corrupt[6] = ~rom_base[6];
        run_seq(18'd0);
        idle_cycle(3'd0);
        mask = 8'd0;

        // start pulses while busy are ignored
        run_seq((18'd1 << 4) | (18'd1 << 12));
        idle_cycle(3'd1);

        // start held high: the second sequence follows the first IDLE cycle
        run_seq({18{1'b1}});
        run_seq(18'd0);
        idle_cycle(3'd2);

        // Reset after four COPY cycles with fresh ROM contents
        for (int i = 0; i < 8; i++) rom_base[i] = 4'($urandom_range(0, 15));
        rd_req     = 1'b0;
        verify_win = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before", int'(busy), 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            ram_model[k-1] = rom_base[k-1];
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_busy_async", int'(busy), 0);
        chk("abort_rom_addr_async", int'(rom_addr), 0);
        chk("abort_done_async", int'(done), 0);
        chk("abort_rd_data_async", int'(rd_data), 0);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = 3'd0;
        for (int i = 0; i < 8; i++) idle_cycle(3'(i));

        // Randomised sequences
        repeat (8) begin
            for (int i = 0; i < 8; i++) begin
                rom_base[i] = 4'($urandom_range(0, 15));
                corrupt[i]  = rom_base[i] ^ 4'($urandom_range(1, 15));
            end
            mask = 8'($urandom & $urandom);
            run_seq(18'($urandom));
            repeat ($urandom_range(1, 3)) idle_cycle(3'($urandom_range(0, 7)));
        end

        rd_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_q_drained", done_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
